// File: rtl/simon_round_ctrl.sv
// Simon Says round controller: LFSR symbol generation, timed playback, keypad scoring.
// Build option: define SIMON_TIMEOUT_EN to enforce the INPUT-phase timeout.
module simon_round_ctrl #(
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 50,
  parameter int OFF_TICKS     = 25,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pb,
  output logic        led_on,
  output logic [3:0]  led_sym,
  output logic [3:0]  state,
  output logic [4:0]  count,
  output logic        win,
  output logic        lose
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GEN      = 4'd1;
  localparam logic [3:0] S_SHOW_ON  = 4'd2;
  localparam logic [3:0] S_SHOW_OFF = 4'd3;
  localparam logic [3:0] S_INPUT    = 4'd4;
  localparam logic [3:0] S_RELEASE  = 4'd5;
  localparam logic [3:0] S_WIN      = 4'd6;
  localparam logic [3:0] S_LOSE     = 4'd7;

  localparam int IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SHOW_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW       = $clog2(SHOW_MAX + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  if (MAX_LEN < 1 || MAX_LEN > 16 || ON_TICKS < 1 || OFF_TICKS < 1 || TIMEOUT_TICKS < 1)
  begin : g_bad_params
    $error("simon_round_ctrl: parameter out of range");
  end

  logic [15:0]   lfsr;
  logic          start_q;
  logic          pb_prev_zero;
  logic [4:0]    len_q, len_d;
  logic [IW-1:0] pos_q, pos_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    state_d;
  logic [3:0]    seq [MAX_LEN];
  logic          seq_we;

`ifdef SIMON_TIMEOUT_EN
  localparam int            OW      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [OW-1:0] TO_LAST = OW'(TIMEOUT_TICKS - 1);
  logic [OW-1:0] timer_q, timer_d;
`endif

  logic       start_edge;
  logic       press;
  logic [3:0] press_sym;
  logic       last_pos;
  logic       lfsr_fb;
  logic       led_on_d;
  logic [3:0] led_sym_d;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign start_edge = start & ~start_q;
  assign press      = (pb != 16'd0) & pb_prev_zero;
  assign last_pos   = (5'(pos_q) + 5'd1) == len_q;

  // Lowest set key wins when several are held together.
  always_comb begin
    press_sym = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pb[i]) press_sym = 4'(i);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state;
    len_d   = len_q;
    pos_d   = pos_q;
    tick_d  = tick_q;
    seq_we  = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    timer_d = '0;
`endif
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_edge) begin
          len_d   = 5'd0;
          pos_d   = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        seq_we  = 1'b1;
        len_d   = len_q + 5'd1;
        pos_d   = '0;
        tick_d  = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tick_q == ON_LAST) begin
          tick_d  = '0;
          state_d = S_SHOW_OFF;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (tick_q == OFF_LAST) begin
          tick_d = '0;
          if (last_pos) begin
            pos_d   = '0;
            state_d = S_INPUT;
          end else begin
            pos_d   = pos_q + IW'(1);
            state_d = S_SHOW_ON;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_INPUT: begin
        if (press) begin
          state_d = (press_sym == seq[pos_q]) ? S_RELEASE : S_LOSE;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (timer_q == TO_LAST) begin
          state_d = S_LOSE;
        end else begin
          timer_d = timer_q + OW'(1);
        end
`endif
      end
      S_RELEASE: begin
        if (pb == 16'd0) begin
          if (last_pos) begin
            state_d = (len_q == LEN_MAX) ? S_WIN : S_GEN;
          end else begin
            pos_d   = pos_q + IW'(1);
            state_d = S_INPUT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The first lit symbol of a game is written on the same edge it is shown, so bypass the array.
  always_comb begin
    led_on_d  = (state_d == S_SHOW_ON);
    led_sym_d = 4'd0;
    if (led_on_d) begin
      if (state == S_GEN && 5'(pos_d) == len_q) led_sym_d = lfsr[3:0];
      else                                      led_sym_d = seq[pos_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lfsr         <= LFSR_SEED;
      start_q      <= 1'b1;
      pb_prev_zero <= 1'b0;
      len_q        <= 5'd0;
      pos_q        <= '0;
      tick_q       <= '0;
`ifdef SIMON_TIMEOUT_EN
      timer_q      <= '0;
`endif
      led_on       <= 1'b0;
      led_sym      <= 4'd0;
      count        <= 5'd0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      state        <= state_d;
      lfsr         <= {lfsr_fb, lfsr[15:1]};
      start_q      <= start;
      pb_prev_zero <= (pb == 16'd0);
      len_q        <= len_d;
      pos_q        <= pos_d;
      tick_q       <= tick_d;
`ifdef SIMON_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
      led_on       <= led_on_d;
      led_sym      <= led_sym_d;
      count        <= len_d;
      win          <= (state_d == S_WIN);
      lose         <= (state_d == S_LOSE);
    end
  end

  // NOTE: the sequence array has no reset; every entry is written in GEN before it is read.
  always_ff @(posedge clk) begin
    if (seq_we && !rst) seq[len_q[IW-1:0]] <= lfsr[3:0];
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: reset, playback, win, wrong key, filtering, timeout.
// Observed playback symbols feed a queue that the next round's replay is scored against.
module tb_simon_round_ctrl;

  localparam int MAX_LEN       = 2;
  localparam int ON_TICKS      = 2;
  localparam int OFF_TICKS     = 1;
  localparam int TIMEOUT_TICKS = 10;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GEN      = 4'd1;
  localparam logic [3:0] S_SHOW_ON  = 4'd2;
  localparam logic [3:0] S_SHOW_OFF = 4'd3;
  localparam logic [3:0] S_INPUT    = 4'd4;
  localparam logic [3:0] S_RELEASE  = 4'd5;
  localparam logic [3:0] S_WIN      = 4'd6;
  localparam logic [3:0] S_LOSE     = 4'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pb;
  logic        led_on;
  logic [3:0]  led_sym;
  logic [3:0]  state;
  logic [4:0]  count;
  logic        win;
  logic        lose;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] seen [$];

  simon_round_ctrl #(
    .MAX_LEN      (MAX_LEN),
    .ON_TICKS     (ON_TICKS),
    .OFF_TICKS    (OFF_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pb     (pb),
    .led_on (led_on),
    .led_sym(led_sym),
    .state  (state),
    .count  (count),
    .win    (win),
    .lose   (lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   state,   S_IDLE);
    check({tag, "_count"},   count,   5'd0);
    check({tag, "_led_on"},  led_on,  1'b0);
    check({tag, "_led_sym"}, led_sym, 4'd0);
    check({tag, "_win"},     win,     1'b0);
    check({tag, "_lose"},    lose,    1'b0);
  endtask

  // Start edge from IDLE/WIN/LOSE: GEN for one cycle with count cleared, then SHOW_ON.
  task automatic start_round();
    seen = {};
    start = 1'b1;
    tick();
    check("start_gen_state", state, S_GEN);
    check("start_gen_count", count, 5'd0);
    check("start_gen_flags", {win, lose}, 2'b00);
    start = 1'b0;
    tick();
  endtask

  // Expects to be called on the first SHOW_ON cycle; ends on the first INPUT cycle.
  task automatic playback(input int n, input bit poke_start);
    logic [3:0] prev [$];
    logic [3:0] s;
    prev = seen;
    seen = {};
    for (int p = 0; p < n; p++) begin
      check("show_on_state", state, S_SHOW_ON);
      check("show_on_led", led_on, 1'b1);
      check("show_count", count, 5'(n));
      if (prev.size() > 0) check("replay_sym", led_sym, prev.pop_front());
      s = led_sym;
      seen.push_back(s);
      if (poke_start && p == 0) start = 1'b1;
      tick();
      check("show_on_hold", {led_on, state}, {1'b1, S_SHOW_ON});
      check("show_sym_stable", led_sym, s);
      start = 1'b0;
      tick();
      check("show_off", {led_on, state}, {1'b0, S_SHOW_OFF});
      tick();
    end
    check("input_entry", {led_on, state}, {1'b0, S_INPUT});
  endtask

  // Press with an extra high key held too, hold through RELEASE, then let go.
  task automatic press_ok(input logic [3:0] sym, input logic [3:0] exp_after);
    pb = 16'h8000 | (16'h0001 << sym);
    tick();
    check("press_release", state, S_RELEASE);
    tick();
    tick();
    check("held_key_release", state, S_RELEASE);
    pb = 16'h0000;
    tick();
    check("after_release", state, exp_after);
  endtask

  initial begin
    logic [3:0] wrong;
    logic [3:0] exp_st;
    logic       zero_sym;

    rst   = 1'b1;
    start = 1'b0;
    pb    = 16'h0000;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    tick();

    // Reset asserted mid-SHOW_ON.
    start = 1'b1;
    tick();
    check("pre_rst_gen", state, S_GEN);
    start = 1'b0;
    tick();
    check("pre_rst_show", {led_on, state}, {1'b1, S_SHOW_ON});
    rst = 1'b1;
    tick();
    check_reset_values("mid_rst");
    rst = 1'b0;
    tick();

    // Round 1 with a start edge during SHOW_ON that must be ignored.
    start_round();
    playback(1, 1'b1);
    press_ok(seen[0], S_GEN);
    tick();
    playback(2, 1'b0);
    press_ok(seen[0], S_INPUT);
    press_ok(seen[1], S_WIN);
    check("win_flags", {win, lose}, 2'b10);
    check("win_count", count, 5'd2);
    tick();
    check("win_hold", {state, win, count}, {S_WIN, 1'b1, 5'd2});

    // Wrong key.
    start_round();
    playback(1, 1'b0);
    wrong = seen[0] + 4'd1;
    pb = 16'h0001 << wrong;
    tick();
    check("wrong_state", state, S_LOSE);
    check("wrong_flags", {win, lose}, 2'b01);
    check("wrong_count", count, 5'd1);
    pb = 16'h0000;
    tick();
    check("lose_hold", {state, lose}, {S_LOSE, 1'b1});

    // Multi-key press decodes to the lowest set bit (symbol 0).
    start_round();
    playback(1, 1'b0);
    zero_sym = (seen[0] == 4'd0);
    exp_st   = zero_sym ? S_RELEASE : S_LOSE;
    pb = 16'h0005;
    tick();
    check("pb_0005", state, exp_st);
    pb = 16'h0000;
    tick();
    if (zero_sym) begin
      check("pb_0005_release", state, S_GEN);
      tick();
      playback(2, 1'b0);
    end else begin
      start_round();
      playback(1, 1'b0);
    end

    // Input timeout.
`ifdef SIMON_TIMEOUT_EN
    repeat (TIMEOUT_TICKS - 1) tick();
    check("timeout_not_yet", state, S_INPUT);
    tick();
    check("timeout_state", state, S_LOSE);
    check("timeout_lose", lose, 1'b1);
`else
    repeat (1000) tick();
    check("no_timeout_state", state, S_INPUT);
    check("no_timeout_lose", lose, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
